// File: rtl/iomem_dbg_pkg.sv
// Shared constants and state encodings for the iomem serial debug initiator.
package iomem_dbg_pkg;

  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] STAT_ACK  = 8'h06;
  localparam logic [7:0] STAT_NAK  = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_STRB,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/iomem_uart_master_if.sv
// iomem initiator bus plus the byte-stream response port toward the serial transmitter.
interface iomem_uart_master_if;

  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic [7:0]  resp_data;
  logic        resp_valid;
  logic        resp_ready;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, resp_data, resp_valid,
    input  iomem_ready, iomem_rdata, resp_ready
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, resp_data, resp_valid,
    output iomem_ready, iomem_rdata, resp_ready
  );

endinterface

// File: rtl/uart_rx8.sv
// 8N1 serial receiver: 2-flop synchroniser, half-bit start re-check, LSB-first
// deserialiser. Emits the byte with a 1-cycle strobe the cycle after the stop
// sample; frames with a low stop bit are silently dropped.
module uart_rx8
  import iomem_dbg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 208
) (
  input  logic       clk24,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_strobe
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic            meta_q, sync_q, prev_q;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            strobe_q, strobe_d;

  // Synchroniser, edge-detect history and receiver state registers.
  always_ff @(posedge clk24) begin
    if (!resetn) begin
      meta_q   <= 1'b1;
      sync_q   <= 1'b1;
      prev_q   <= 1'b1;
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      meta_q   <= rx;
      sync_q   <= meta_q;
      prev_q   <= sync_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      strobe_q <= strobe_d;
    end
  end

  // Bit timer down-counts to zero; each terminal count is a bit-centre sample.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    strobe_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync_q) begin
          state_d = RX_START;
          cnt_d   = HALF;
        end
      end
      RX_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (sync_q) begin
          state_d = RX_IDLE;
        end else begin
          state_d = RX_DATA;
          cnt_d   = FULL;
          bit_d   = 3'd0;
        end
      end
      RX_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d = {sync_q, shift_q[7:1]};
          cnt_d   = FULL;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d  = RX_IDLE;
          strobe_d = sync_q;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_byte   = shift_q;
  assign rx_strobe = strobe_q;

endmodule

// File: rtl/iomem_uart_master.sv
// Serial-command iomem bus initiator. One read or write per received frame,
// status (and read data) returned on the byte-stream response port.
// Optional BUS timeout: define IOMEM_UART_MASTER_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for a command byte
// ADDR    | collecting 4 address bytes, MSB first
// STRB    | collecting the write strobe byte
// DATA    | collecting 4 write data bytes, MSB first
// BUS     | iomem_valid high, waiting for iomem_ready
// RESP    | streaming queued response bytes
module iomem_uart_master
  import iomem_dbg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 208
`ifdef IOMEM_UART_MASTER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                clk24,
  input  logic                resetn,
  input  logic                rx,
  iomem_uart_master_if.master bus,
  output logic                busy
);

`ifdef IOMEM_UART_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q, to_d;
`endif

  logic [7:0]  rx_byte;
  logic        rx_strobe;
  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  left_q, left_d;
  logic [7:0]  resp_data_q, resp_data_d;
  logic        resp_valid_q, resp_valid_d;
  logic        enter_bus;

  uart_rx8 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk24     (clk24),
    .resetn    (resetn),
    .rx        (rx),
    .rx_byte   (rx_byte),
    .rx_strobe (rx_strobe)
  );

  // Command FSM, transaction fields and response queue registers.
  always_ff @(posedge clk24) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      wr_q         <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      left_q       <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
`ifdef IOMEM_UART_MASTER_TIMEOUT_EN
      to_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      left_q       <= left_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
`ifdef IOMEM_UART_MASTER_TIMEOUT_EN
      to_q         <= to_d;
`endif
    end
  end

  // Next-state: frame parsing, bus request/completion and response sequencing.
  // data_q doubles as the read-data shifter; left_q counts bytes still to follow.
  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    valid_d      = valid_q;
    data_d       = data_q;
    left_d       = left_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = resp_valid_q;
    enter_bus    = 1'b0;
`ifdef IOMEM_UART_MASTER_TIMEOUT_EN
    to_d         = to_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_strobe) begin
          if (rx_byte == CMD_READ || rx_byte == CMD_WRITE) begin
            state_d = ST_ADDR;
            cnt_d   = 2'd0;
            wr_d    = (rx_byte == CMD_WRITE);
            wstrb_d = 4'h0;
          end else begin
            state_d      = ST_RESP;
            resp_data_d  = STAT_NAK;
            resp_valid_d = 1'b1;
            left_d       = 3'd0;
          end
        end
      end
      ST_ADDR: begin
        if (rx_strobe) begin
          addr_d = {addr_q[23:0], rx_byte};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (wr_q) state_d = ST_STRB;
            else      enter_bus = 1'b1;
          end
        end
      end
      ST_STRB: begin
        if (rx_strobe) begin
          wstrb_d = rx_byte[3:0];
          cnt_d   = 2'd0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_strobe) begin
          wdata_d = {wdata_q[23:0], rx_byte};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) enter_bus = 1'b1;
        end
      end
      ST_BUS: begin
        if (bus.iomem_ready) begin
          valid_d      = 1'b0;
          data_d       = bus.iomem_rdata;
          resp_data_d  = STAT_ACK;
          resp_valid_d = 1'b1;
          left_d       = wr_q ? 3'd0 : 3'd4;
          state_d      = ST_RESP;
        end
`ifdef IOMEM_UART_MASTER_TIMEOUT_EN
        else if (to_q == '0) begin
          valid_d      = 1'b0;
          resp_data_d  = STAT_NAK;
          resp_valid_d = 1'b1;
          left_d       = 3'd0;
          state_d      = ST_RESP;
        end else begin
          to_d = to_q - TW'(1);
        end
`endif
      end
      ST_RESP: begin
        if (resp_valid_q && bus.resp_ready) begin
          if (left_q == 3'd0) begin
            resp_valid_d = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            resp_data_d = data_q[31:24];
            data_d      = {data_q[23:0], 8'h00};
            left_d      = left_q - 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (enter_bus) begin
      state_d = ST_BUS;
      valid_d = 1'b1;
`ifdef IOMEM_UART_MASTER_TIMEOUT_EN
      to_d    = TW'(TIMEOUT_CYCLES - 1);
`endif
    end
  end

  assign bus.iomem_valid = valid_q;
  assign bus.iomem_wstrb = wstrb_q;
  assign bus.iomem_addr  = addr_q;
  assign bus.iomem_wdata = wdata_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.resp_valid  = resp_valid_q;
  assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_iomem_uart_master.sv
// Directed bench for iomem_uart_master: frames are sent serially, a frame-level
// model predicts the bus request and response bytes, and a compare process
// checks the DUT against it every cycle.
module tb_iomem_uart_master;

  localparam int CPB   = 16;
  localparam int TOCYC = 16;

  logic clk24  = 1'b0;
  logic resetn = 1'b0;
  logic rx     = 1'b1;
  logic busy;

  int n_tests = 0;
  int n_fail  = 0;

  iomem_uart_master_if bus ();

  iomem_uart_master #(
    .CLKS_PER_BIT(CPB)
`ifdef IOMEM_UART_MASTER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TOCYC)
`endif
  ) dut (
    .clk24  (clk24),
    .resetn (resetn),
    .rx     (rx),
    .bus    (bus.master),
    .busy   (busy)
  );

  always #5 clk24 = ~clk24;

  // model state
  logic [7:0]  frm[$];
  logic [7:0]  exp_resp[$];
  logic [7:0]  got_resp[$];
  logic        exp_req_on = 1'b0;
  logic        exp_wr = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_wstrb = '0;
  int          exp_vlen = 0;
  // responder control
  int          rsp_delay = 0;
  bit          rsp_never = 1'b0;
  logic [31:0] rsp_rdata = '0;
  // observed history
  int          n_req = 0;
  int          last_vlen = 0;
  logic [31:0] last_addr = '0, last_wdata = '0;
  logic [3:0]  last_wstrb = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk24);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = stop_bit;
    repeat (CPB) tick();
    rx = 1'b1;
  endtask

  task automatic load_frame(input logic [79:0] v, input int n);
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(v[8*(n-1-i) +: 8]);
  endtask

  // Frame-level model: decide the request and the response bytes, then send.
  task automatic do_frame(input logic [31:0] rdata, input int delay, input bit never);
    rsp_rdata = rdata;
    rsp_delay = delay;
    rsp_never = never;
    got_resp.delete();
    exp_wr     = (frm[0] == 8'h57);
    exp_req_on = (frm[0] == 8'h52) || exp_wr;
    if (exp_req_on) begin
      exp_addr  = {frm[1], frm[2], frm[3], frm[4]};
      exp_wstrb = exp_wr ? frm[5][3:0] : 4'h0;
      exp_wdata = exp_wr ? {frm[6], frm[7], frm[8], frm[9]} : 32'h0;
      exp_vlen  = never ? TOCYC : delay + 1;
    end
    if (!exp_req_on || never) begin
      exp_resp.push_back(8'h15);
    end else begin
      exp_resp.push_back(8'h06);
      if (!exp_wr) begin
        exp_resp.push_back(rdata[31:24]);
        exp_resp.push_back(rdata[23:16]);
        exp_resp.push_back(rdata[15:8]);
        exp_resp.push_back(rdata[7:0]);
      end
    end
    foreach (frm[i]) send_byte(frm[i], 1'b1);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 3000 && (exp_resp.size() != 0 || busy); i++) tick();
    chk({name, "_done"}, {31'b0, exp_resp.size() == 0 && !busy}, 32'd1);
  endtask

  // Responder: ready in the (delay+1)-th valid cycle, random rdata otherwise.
  initial begin : responder
    int k;
    k = 0;
    bus.iomem_ready = 1'b0;
    bus.iomem_rdata = '0;
    forever begin
      @(negedge clk24);
      if (bus.iomem_valid && resetn) begin
        k++;
        bus.iomem_ready = !rsp_never && (k > rsp_delay);
        bus.iomem_rdata = bus.iomem_ready ? rsp_rdata : $urandom();
      end else begin
        k = 0;
        bus.iomem_ready = 1'b0;
      end
    end
  end

  // Compare process: request fields, request length, busy, response stream and hold.
  initial begin : compare
    int vlen;
    logic prev_hold;
    logic [7:0] hold_data;
    vlen = 0;
    prev_hold = 1'b0;
    hold_data = '0;
    forever begin
      @(negedge clk24);
      if (resetn) begin
        if (bus.iomem_valid) begin
          vlen++;
          if (vlen == 1) begin
            n_req++;
            last_addr  = bus.iomem_addr;
            last_wstrb = bus.iomem_wstrb;
            last_wdata = bus.iomem_wdata;
            chk("req_expected", {31'b0, exp_req_on}, 32'd1);
          end
          chk("addr", bus.iomem_addr, exp_addr);
          chk("wstrb", {28'b0, bus.iomem_wstrb}, {28'b0, exp_wstrb});
          if (exp_wr) chk("wdata", bus.iomem_wdata, exp_wdata);
        end else if (vlen != 0) begin
          last_vlen = vlen;
          chk("valid_len", vlen, exp_vlen);
          exp_req_on = 1'b0;
          vlen = 0;
        end
        if (bus.iomem_valid || bus.resp_valid) chk("busy", {31'b0, busy}, 32'd1);
        if (prev_hold) begin
          chk("hold_valid", {31'b0, bus.resp_valid}, 32'd1);
          chk("hold_data", {24'b0, bus.resp_data}, {24'b0, hold_data});
        end
        if (bus.resp_valid && bus.resp_ready) begin
          got_resp.push_back(bus.resp_data);
          chk("resp_queued", {31'b0, exp_resp.size() != 0}, 32'd1);
          if (exp_resp.size() != 0) chk("resp_byte", {24'b0, bus.resp_data}, {24'b0, exp_resp.pop_front()});
        end
        prev_hold = bus.resp_valid && !bus.resp_ready;
        hold_data = bus.resp_data;
      end else begin
        vlen = 0;
        prev_hold = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] lit[5];
    int n_before;
    bit saw_busy;
    bus.resp_ready = 1'b1;

    // reset state
    resetn = 1'b0;
    repeat (5) tick();
    chk("rst_valid", {31'b0, bus.iomem_valid}, 32'd0);
    chk("rst_wstrb", {28'b0, bus.iomem_wstrb}, 32'd0);
    chk("rst_addr", bus.iomem_addr, 32'd0);
    chk("rst_wdata", bus.iomem_wdata, 32'd0);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_resp_data", {24'b0, bus.resp_data}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    resetn = 1'b1;
    repeat (3) tick();

    // read, ready after 3 cycles
    load_frame(80'h52_03000000, 5);
    do_frame(32'h0000_0004, 3, 1'b0);
    wait_done("read");
    chk("read_addr_lit", last_addr, 32'h0300_0000);
    chk("read_wstrb_lit", {28'b0, last_wstrb}, 32'd0);
    chk("read_vlen_lit", last_vlen, 32'd4);
    lit = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h04};
    chk("read_nbytes_lit", got_resp.size(), 32'd5);
    for (int i = 0; i < 5 && i < got_resp.size(); i++) chk("read_byte_lit", {24'b0, got_resp[i]}, {24'b0, lit[i]});

    // write, ready in the first valid cycle
    n_before = n_req;
    load_frame(80'h57_03000000_01_00000005, 10);
    do_frame(32'hFFFF_FFFF, 0, 1'b0);
    wait_done("write");
    chk("write_nreq", n_req, n_before + 1);
    chk("write_wstrb_lit", {28'b0, last_wstrb}, 32'd1);
    chk("write_wdata_lit", last_wdata, 32'h0000_0005);
    chk("write_vlen_lit", last_vlen, 32'd1);
    chk("write_nbytes_lit", got_resp.size(), 32'd1);
    if (got_resp.size() > 0) chk("write_ack_lit", {24'b0, got_resp[0]}, 32'h06);

    // bad command
    n_before = n_req;
    load_frame(80'h41, 1);
    do_frame(32'h0, 0, 1'b0);
    wait_done("badcmd");
    chk("badcmd_noreq", n_req, n_before);
    if (got_resp.size() > 0) chk("badcmd_nak_lit", {24'b0, got_resp[0]}, 32'h15);

    // framing error on an 'R' byte: no FSM activity
    n_before = n_req;
    saw_busy = 1'b0;
    send_byte(8'h52, 1'b0);
    for (int i = 0; i < 4 * CPB; i++) begin
      tick();
      if (busy) saw_busy = 1'b1;
    end
    chk("frame_err_busy", {31'b0, saw_busy}, 32'd0);
    chk("frame_err_noreq", n_req, n_before);

    // write with zero strobe is still issued, write-format response
    load_frame(80'h57_00000010_00_DEADBEEF, 10);
    do_frame(32'h1234_5678, 2, 1'b0);
    wait_done("write_s0");

    // read with response backpressure
    bus.resp_ready = 1'b0;
    load_frame(80'h52_03000004, 5);
    do_frame(32'hA1B2_C3D4, 1, 1'b0);
    for (int i = 0; i < 200 && !bus.resp_valid; i++) tick();
    chk("bp_valid", {31'b0, bus.resp_valid}, 32'd1);
    repeat (50) tick();
    chk("bp_first_lit", {24'b0, bus.resp_data}, 32'h06);
    bus.resp_ready = 1'b1;
    wait_done("bp");
    lit = '{8'h06, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    chk("bp_nbytes_lit", got_resp.size(), 32'd5);
    for (int i = 0; i < 5 && i < got_resp.size(); i++) chk("bp_byte_lit", {24'b0, got_resp[i]}, {24'b0, lit[i]});

`ifdef IOMEM_UART_MASTER_TIMEOUT_EN
    // timeout: responder never answers
    load_frame(80'h52_03000000, 5);
    do_frame(32'h0, 0, 1'b1);
    wait_done("timeout");
    chk("timeout_vlen_lit", last_vlen, 32'd16);
    if (got_resp.size() > 0) chk("timeout_nak_lit", {24'b0, got_resp[0]}, 32'h15);
`endif

    // reset while the request is outstanding
    load_frame(80'h52_03000008, 5);
    do_frame(32'h0, 0, 1'b1);
    for (int i = 0; i < 200 && !bus.iomem_valid; i++) tick();
    chk("midbus_valid", {31'b0, bus.iomem_valid}, 32'd1);
    resetn = 1'b0;
    exp_resp.delete();
    exp_req_on = 1'b0;
    tick();
    chk("midbus_drop", {31'b0, bus.iomem_valid}, 32'd0);
    chk("midbus_noresp", {31'b0, bus.resp_valid}, 32'd0);
    chk("midbus_busy", {31'b0, busy}, 32'd0);
    repeat (3) tick();
    resetn = 1'b1;
    repeat (3) tick();
    load_frame(80'h52_0300000C, 5);
    do_frame(32'hCAFE_0001, 2, 1'b0);
    wait_done("after_rst");
    chk("after_rst_nbytes", got_resp.size(), 32'd5);
    chk("after_rst_addr_lit", last_addr, 32'h0300_000C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
